// File: rtl/crt_pkg.sv
// Shared CRT timing constants and the fetch FSM encoding, imported by the
// timing generator and the video shifter.
package crt_pkg;
   localparam int H_TOTAL        = 704;
   localparam int V_TOTAL        = 370;
   localparam int H_START        = 15;
   localparam int H_ACTIVE       = 512;
   localparam int V_START        = 29;
   localparam int V_ACTIVE       = 342;
   localparam int WORD_W         = 16;
   localparam int WORDS_PER_LINE = H_ACTIVE / WORD_W;
   localparam int PREFETCH_LEAD  = 32;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_WAIT = 2'd2
   } fetch_state_t;

   // Dot at which line prefetch starts. When the lead reaches back past dot 1
   // it wraps onto the tail of the preceding line.
   function automatic int open_dot(int h_start, int lead, int h_total);
      return (h_start > lead) ? (h_start - lead) : (h_start - lead + h_total);
   endfunction
endpackage

// File: rtl/crt_word_fifo.sv
// Two-entry framebuffer word FIFO with synchronous flush; pop on empty is ignored.
module crt_word_fifo (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        push,
   input  logic [15:0] push_data,
   input  logic        pop,
   output logic [15:0] head,
   output logic [1:0]  count
);
   import crt_pkg::*;

   logic [1:0][WORD_W-1:0] mem;
   logic                   rd_ptr, wr_ptr;
   logic                   do_push, do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   // The fetcher only issues with a free slot and one request in flight.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && !flush && count == 2'd2));
endmodule

// File: rtl/crt_video_shifter.sv
// Fetches framebuffer words over a req/ack port ahead of each active line and
// serializes them MSB-first onto the registered video output.
module crt_video_shifter #(
   parameter int          H_START        = crt_pkg::H_START,
   parameter int          H_ACTIVE       = crt_pkg::H_ACTIVE,
   parameter int          V_START        = crt_pkg::V_START,
   parameter int          V_ACTIVE       = crt_pkg::V_ACTIVE,
   parameter int          WORDS_PER_LINE = crt_pkg::WORDS_PER_LINE,
   parameter logic [15:0] BASE_ADDR      = 16'h0000,
   parameter int          PREFETCH_LEAD  = crt_pkg::PREFETCH_LEAD,
   parameter bit          INVERT         = 1'b1
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic [15:0] h_count,
   input  logic [15:0] v_count,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_data,
   output logic        video,
   output logic        underrun
);
   import crt_pkg::*;

   localparam int OPEN_DOT  = open_dot(H_START, PREFETCH_LEAD, H_TOTAL);
   localparam bit OPEN_WRAP = (H_START <= PREFETCH_LEAD);
   localparam int H_LAST    = H_START + H_ACTIVE - 1;
   localparam int V_LAST    = V_START + V_ACTIVE - 1;
   localparam int ISS_W     = $clog2(WORDS_PER_LINE + 1);

   fetch_state_t      state, state_nxt;
   logic [ISS_W-1:0]  issued, cur_issued;
   logic [15:0]       line_q, cur_line, tgt_line, fetch_addr;
   logic [16:0]       tgt_v;
   logic              fetch_en, discard, cur_en, cur_room, start_req;
   logic              active_line, active_dot, window_open, tgt_active;
   logic              load_dot, push, pixel;
   logic [3:0]        dot_phase;
   logic [15:0]       fifo_head, load_word, sr, sr_nxt;
   logic [1:0]        fifo_count;

   assign active_line = (v_count >= 16'(V_START)) && (v_count <= 16'(V_LAST));
   assign active_dot  = active_line && (h_count >= 16'(H_START)) && (h_count <= 16'(H_LAST));
   assign dot_phase   = h_count[3:0] - 4'(H_START);
   assign load_dot    = active_dot && (dot_phase == 4'd0);
   assign window_open = (h_count == 16'(OPEN_DOT));

   // A wrapped window opens on the preceding line, so it targets v_count+1.
   assign tgt_v      = {1'b0, v_count} + (OPEN_WRAP ? 17'd1 : 17'd0);
   assign tgt_active = (tgt_v >= 17'(V_START)) && (tgt_v <= 17'(V_LAST));
   assign tgt_line   = tgt_v[15:0] - 16'(V_START);

   // Window open restarts the line this cycle, so the first request needs no extra dot.
   assign cur_en     = window_open ? tgt_active : fetch_en;
   assign cur_issued = window_open ? '0 : issued;
   assign cur_line   = window_open ? tgt_line : line_q;
   assign cur_room   = window_open ? 1'b1 : (fifo_count < 2'd2);
   assign start_req  = cur_en && (cur_issued < ISS_W'(WORDS_PER_LINE)) && cur_room;
   assign fetch_addr = BASE_ADDR + cur_line * 16'(WORDS_PER_LINE) + 16'(cur_issued);

   // A request straddling a window open belongs to the old line; its data is dropped.
   assign push = (state == FS_REQ) && mem_ack && !discard && !window_open;

   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      case (state)
         FS_REQ: begin
            mem_req = 1'b1;
            if (mem_ack) state_nxt = FS_IDLE;
         end
         default: if (start_req) state_nxt = FS_REQ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state    <= FS_IDLE;
         mem_addr <= '0;
         issued   <= '0;
         line_q   <= '0;
         fetch_en <= 1'b0;
         discard  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state != FS_REQ && start_req) mem_addr <= fetch_addr;
         if (window_open) begin
            issued   <= '0;
            line_q   <= tgt_line;
            fetch_en <= tgt_active;
         end else if (push) begin
            issued <= issued + ISS_W'(1);
         end
         if (state == FS_REQ && mem_ack)           discard <= 1'b0;
         else if (state == FS_REQ && window_open)  discard <= 1'b1;
      end
   end

   crt_word_fifo u_fifo (
      .clk       (clk_in),
      .rst       (rst),
      .flush     (window_open),
      .push      (push),
      .push_data (mem_data),
      .pop       (load_dot),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign load_word = (fifo_count != 2'd0) ? fifo_head : 16'h0000;
   assign sr_nxt    = load_dot ? load_word : (active_dot ? {sr[14:0], 1'b0} : sr);
   assign pixel     = sr_nxt[15];

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sr       <= '0;
         video    <= INVERT;
         underrun <= 1'b0;
      end else begin
         sr    <= sr_nxt;
         video <= active_dot ? (pixel ^ INVERT) : INVERT;
         if (load_dot && fifo_count == 2'd0) underrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_crt_video_shifter.sv
// Bench for crt_video_shifter: drives the dot/line counters, models a req/ack
// memory of configurable latency, and scoreboards video bits and fetch addresses.
module tb_crt_video_shifter;
   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] h_count = '0, v_count = '0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_data = '0;
   logic        video, underrun;

   localparam int H_OPEN = 687;

   crt_video_shifter dut (
      .clk_in(clk_in), .rst(rst), .h_count(h_count), .v_count(v_count),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .video(video), .underrun(underrun)
   );

   always #5 clk_in = ~clk_in;

   int          checks = 0, errors = 0;
   int          hh, vv, last_h, last_v;
   int          lat = 0, dmode = 0, req_age = 0, addr_hits = 0;
   bit          sb_en = 0, addr_chk = 0, hold_pos = 0;
   logic [15:0] req_addr0, last_ack_addr;
   logic [15:0] cap;
   logic        exp_vid_q[$];
   logic [15:0] exp_addr_q[$];

   function automatic logic [15:0] data_of(logic [15:0] a);
      return (dmode == 0) ? 16'hA5F0 : a;
   endfunction

   function automatic logic exp_video(int v, int h);
      logic [15:0] wd;
      if (v >= 29 && v <= 370 && h >= 15 && h <= 526) begin
         wd = data_of(16'((v - 29) * 32 + (h - 15) / 16));
         return ~wd[15 - ((h - 15) % 16)];
      end
      return 1'b1;
   endfunction

   task automatic tick();
      logic e;
      logic [15:0] ea;
      h_count = 16'(hh);
      v_count = 16'(vv);
      mem_ack = 1'b0;
      if (addr_chk && hh == H_OPEN && vv + 1 >= 29 && vv + 1 <= 370)
         for (int w = 0; w < 32; w++) exp_addr_q.push_back(16'((vv + 1 - 29) * 32 + w));
      if (mem_req === 1'b1) begin
         if (req_age == 0) req_addr0 = mem_addr;
         if (req_age >= lat) begin
            mem_ack = 1'b1;
            mem_data = data_of(mem_addr);
            last_ack_addr = mem_addr;
            checks++;
            if (mem_addr !== req_addr0) begin
               errors++;
               $display("FAIL addr_stable: got %h required %h", mem_addr, req_addr0);
            end
            if (addr_chk) begin
               checks++;
               if (exp_addr_q.size() == 0) begin
                  errors++;
                  $display("FAIL addr_order: got %h required none", mem_addr);
               end else begin
                  ea = exp_addr_q.pop_front();
                  if (mem_addr !== ea) begin
                     errors++;
                     $display("FAIL addr_order: got %h required %h", mem_addr, ea);
                  end else addr_hits++;
               end
            end
         end
         req_age++;
      end else req_age = 0;
      if (sb_en) exp_vid_q.push_back(exp_video(vv, hh));
      @(posedge clk_in);
      #1;
      if (sb_en) begin
         e = exp_vid_q.pop_front();
         checks++;
         if (video !== e) begin
            errors++;
            $display("FAIL video v=%0d h=%0d: got %b required %b", vv, hh, video, e);
         end
      end
      if (vv == 29 && hh >= 15 && hh <= 30) cap[30 - hh] = video;
      last_h = hh;
      last_v = vv;
      if (!hold_pos) begin
         hh++;
         if (hh > 704) begin hh = 1; vv++; end
      end
   endtask

   task automatic do_reset(int v, int h);
      vv = v; hh = h; hold_pos = 0;
      sb_en = 0; addr_chk = 0;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      exp_vid_q.delete();
      exp_addr_q.delete();
      addr_hits = 0;
   endtask

   task automatic test_reset();
      bit found = 0;
      vv = 28; hh = 600; lat = 0; dmode = 0; sb_en = 0; addr_chk = 0;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks += 3;
         if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", mem_req); end
         if (video !== 1'b1) begin errors++; $display("FAIL reset_video: got %b required 1", video); end
         if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b required 0", underrun); end
      end
      rst = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (mem_req === 1'b1) begin
            found = 1;
            checks += 2;
            if (last_h != H_OPEN || last_v != 28) begin
               errors++;
               $display("FAIL first_req_pos: got v=%0d h=%0d required v=28 h=%0d", last_v, last_h, H_OPEN);
            end
            if (mem_addr !== 16'h0000) begin
               errors++;
               $display("FAIL first_req_addr: got %h required 0000", mem_addr);
            end
         end
      end
      if (!found) begin checks++; errors++; $display("FAIL first_req_timeout: got none required request"); end
   endtask

   task automatic test_zero_wait();
      lat = 0; dmode = 0;
      do_reset(28, 600);
      addr_chk = 1; sb_en = 1;
      while (!(vv == 30 && hh == 100)) tick();
      checks += 3;
      if (cap !== 16'h5A0F) begin errors++; $display("FAIL zw_pattern: got %h required 5a0f", cap); end
      if (underrun !== 1'b0) begin errors++; $display("FAIL zw_underrun: got %b required 0", underrun); end
      if (addr_hits < 32) begin errors++; $display("FAIL zw_fetch_count: got %0d required >=32", addr_hits); end
   endtask

   task automatic test_latency3();
      lat = 3; dmode = 1;
      do_reset(29, 600);
      addr_chk = 1; sb_en = 1;
      while (!(vv == 31 && hh == 20)) tick();
      checks += 2;
      if (underrun !== 1'b0) begin errors++; $display("FAIL l3_underrun: got %b required 0", underrun); end
      if (addr_hits < 32) begin errors++; $display("FAIL l3_fetch_count: got %0d required >=32", addr_hits); end
   endtask

   task automatic test_underrun();
      lat = 40; dmode = 0;
      do_reset(28, 600);
      while (!(vv == 29 && hh == 15)) tick();
      checks++;
      if (underrun !== 1'b0) begin errors++; $display("FAIL ur_before: got %b required 0", underrun); end
      for (int d = 15; d <= 30; d++) begin
         tick();
         checks++;
         if (video !== 1'b1) begin errors++; $display("FAIL ur_blank h=%0d: got %b required 1", d, video); end
         if (d == 15) begin
            checks++;
            if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set: got %b required 1", underrun); end
         end
      end
      tick();
      checks++;
      if (video !== 1'b0) begin errors++; $display("FAIL ur_late_word: got %b required 0", video); end
      while (!(vv == 29 && hh == 400)) tick();
      checks++;
      if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b required 1", underrun); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b required 0", underrun); end
   endtask

   task automatic test_last_line();
      int late = 0;
      lat = 0; dmode = 1;
      do_reset(369, 600);
      addr_chk = 1; sb_en = 1;
      while (!(vv == 372 && hh == 1)) begin
         tick();
         if (mem_req === 1'b1 && (last_v >= 371 || (last_v == 370 && last_h >= 600))) late++;
      end
      vv = 0; hh = 0; hold_pos = 1;
      repeat (40) begin
         tick();
         if (mem_req === 1'b1) late++;
      end
      hold_pos = 0;
      checks += 3;
      if (late != 0) begin errors++; $display("FAIL ll_inactive_req: got %0d required 0", late); end
      if (last_ack_addr !== 16'((370 - 29) * 32 + 31)) begin
         errors++;
         $display("FAIL ll_last_addr: got %h required %h", last_ack_addr, 16'((370 - 29) * 32 + 31));
      end
      if (addr_hits < 32) begin errors++; $display("FAIL ll_fetch_count: got %0d required >=32", addr_hits); end
   endtask

   task automatic test_reset_mid_req();
      bit found = 0, first = 0;
      int early = 0;
      lat = 40; dmode = 1;
      do_reset(28, 600);
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (mem_req === 1'b1) found = 1;
      end
      if (!found) begin checks++; errors++; $display("FAIL mr_req_timeout: got none required request"); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL mr_drop: got %b required 0", mem_req); end
      lat = 0; req_age = 0;
      exp_vid_q.delete();
      exp_addr_q.delete();
      addr_hits = 0;
      while (!(vv == 29 && hh == 600)) begin
         tick();
         if (mem_req === 1'b1) early++;
      end
      checks++;
      if (early != 0) begin errors++; $display("FAIL mr_early_req: got %0d required 0", early); end
      sb_en = 1; addr_chk = 1;
      while (!(vv == 31 && hh == 20)) begin
         tick();
         if (mem_req === 1'b1 && !first) begin
            first = 1;
            checks += 2;
            if (last_v != 29 || last_h != H_OPEN) begin
               errors++;
               $display("FAIL mr_restart_pos: got v=%0d h=%0d required v=29 h=%0d", last_v, last_h, H_OPEN);
            end
            if (mem_addr !== 16'h0020) begin
               errors++;
               $display("FAIL mr_restart_addr: got %h required 0020", mem_addr);
            end
         end
      end
      if (!first) begin checks++; errors++; $display("FAIL mr_restart_timeout: got none required request"); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_latency3();
      test_underrun();
      test_last_line();
      test_reset_mid_req();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
